// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Decode-stage hazard detection, jump flush sequencing and
//               registered operand-forward selection for a 5-stage pipeline.
//               Build option HAZARD_FORWARD_EN: only load-use stalls, the
//               rest is resolved by forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [4:0]             dec_rs1_idx,
    input  logic [4:0]             dec_rs2_idx,
    input  logic                   dec_use_rs1,
    input  logic                   dec_use_rs2,
    input  logic [4:0]             ex_rd_idx,
    input  logic                   ex_reg_write,
    input  logic                   ex_mem_load,
    input  logic [4:0]             mem_rd_idx,
    input  logic                   mem_reg_write,
    input  logic                   jump_taken,
    output logic                   stall,
    output logic                   bubble_ex,
    output logic                   flush_dec,
    output logic [1:0]             fwd_rs1_sel,
    output logic [1:0]             fwd_rs2_sel,
    output logic                   busy_flush,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0]             c_flush_init = 3'(FLUSH_CYCLES - 1);
    localparam logic [STALL_CNT_W-1:0] c_cnt_max    = '1;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [2:0]               r_flush_cnt;
    logic [2:0]               w_flush_cnt_nxt;
    logic                     w_stall;
    logic                     w_bubble;
    logic                     w_flush;
    logic                     w_hazard;
    logic [STALL_CNT_W-1:0]   r_stall_cycles;

    // Source/producer matches; x0 is hard-wired zero and never a hazard.
    logic w_ex_match_rs1;
    logic w_ex_match_rs2;
    logic w_mem_match_rs1;
    logic w_mem_match_rs2;

    assign w_ex_match_rs1  = dec_use_rs1 && ex_reg_write  &&
                             (ex_rd_idx  == dec_rs1_idx) && (dec_rs1_idx != 5'd0);
    assign w_ex_match_rs2  = dec_use_rs2 && ex_reg_write  &&
                             (ex_rd_idx  == dec_rs2_idx) && (dec_rs2_idx != 5'd0);
    assign w_mem_match_rs1 = dec_use_rs1 && mem_reg_write &&
                             (mem_rd_idx == dec_rs1_idx) && (dec_rs1_idx != 5'd0);
    assign w_mem_match_rs2 = dec_use_rs2 && mem_reg_write &&
                             (mem_rd_idx == dec_rs2_idx) && (dec_rs2_idx != 5'd0);

`ifdef HAZARD_FORWARD_EN
    assign w_hazard = (w_ex_match_rs1 || w_ex_match_rs2) && ex_mem_load;
`else
    assign w_hazard = w_ex_match_rs1 || w_ex_match_rs2 ||
                      w_mem_match_rs1 || w_mem_match_rs2;

    logic w_unused_ok;
    assign w_unused_ok = ex_mem_load;
`endif

    // ------------------------------------------------------------------
    // FSM: flush_cnt holds the FLUSH cycles still to run, including the
    // current one, so the jump cycle plus the FLUSH cycles squash exactly
    // FLUSH_CYCLES wrong-path instructions.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= RUN;
            r_flush_cnt <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_stall         = 1'b0;
        w_bubble        = 1'b0;
        w_flush         = 1'b0;
        case (r_state)
            RUN: begin
                if (jump_taken) begin
                    w_flush  = 1'b1;
                    w_bubble = 1'b1;
                    if (c_flush_init != 3'd0) begin
                        w_state_nxt     = FLUSH;
                        w_flush_cnt_nxt = c_flush_init;
                    end
                end else if (w_hazard) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end
            end
            FLUSH: begin
                w_flush         = 1'b1;
                w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                if (r_flush_cnt <= 3'd1) begin
                    w_state_nxt     = RUN;
                    w_flush_cnt_nxt = 3'd0;
                end
            end
            default: begin
                w_state_nxt     = RUN;
                w_flush_cnt_nxt = 3'd0;
            end
        endcase
    end

    // Pipeline controls are gated so nothing disturbs the pipe during reset.
    assign stall      = w_stall  & reset_n;
    assign bubble_ex  = w_bubble & reset_n;
    assign flush_dec  = w_flush  & reset_n;
    assign busy_flush = (r_state == FLUSH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != c_cnt_max)) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles = r_stall_cycles;

`ifdef HAZARD_FORWARD_EN
    logic [1:0] r_fwd_rs1_sel;
    logic [1:0] r_fwd_rs2_sel;
    logic       w_squash;

    assign w_squash = w_stall || w_bubble || w_flush;

    function automatic logic [1:0] sel_src(input logic ex_m, input logic mem_m);
        if (ex_m)
            return 2'b01;
        else if (mem_m)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fwd_rs1_sel <= 2'b00;
            r_fwd_rs2_sel <= 2'b00;
        end else if (w_squash) begin
            r_fwd_rs1_sel <= 2'b00;
            r_fwd_rs2_sel <= 2'b00;
        end else begin
            r_fwd_rs1_sel <= sel_src(w_ex_match_rs1, w_mem_match_rs1);
            r_fwd_rs2_sel <= sel_src(w_ex_match_rs2, w_mem_match_rs2);
        end
    end

    assign fwd_rs1_sel = r_fwd_rs1_sel;
    assign fwd_rs2_sel = r_fwd_rs2_sel;
`else
    assign fwd_rs1_sel = 2'b00;
    assign fwd_rs2_sel = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench: two instances (FLUSH 2/CNT 16 and
//               FLUSH 3/CNT 2) against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
    localparam bit c_fwd_on = 1'b1;
`else
    localparam bit c_fwd_on = 1'b0;
`endif
    localparam int c_fc0 = 2;
    localparam int c_fc1 = 3;
    localparam int c_cw0 = 16;
    localparam int c_cw1 = 2;

    logic clk;
    logic reset_n;
    logic [4:0] rs1, rs2, exrd, memrd;
    logic u1, u2, exw, exl, memw, jmp;

    logic a_stall, a_bub, a_flush, a_busy;
    logic [1:0] a_f1, a_f2;
    logic [c_cw0-1:0] a_cnt;
    logic b_stall, b_bub, b_flush, b_busy;
    logic [1:0] b_f1, b_f2;
    logic [c_cw1-1:0] b_cnt;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(c_fc0), .STALL_CNT_W(c_cw0)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .dec_rs1_idx(rs1), .dec_rs2_idx(rs2), .dec_use_rs1(u1), .dec_use_rs2(u2),
        .ex_rd_idx(exrd), .ex_reg_write(exw), .ex_mem_load(exl),
        .mem_rd_idx(memrd), .mem_reg_write(memw), .jump_taken(jmp),
        .stall(a_stall), .bubble_ex(a_bub), .flush_dec(a_flush),
        .fwd_rs1_sel(a_f1), .fwd_rs2_sel(a_f2), .busy_flush(a_busy),
        .stall_cycles(a_cnt)
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(c_fc1), .STALL_CNT_W(c_cw1)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .dec_rs1_idx(rs1), .dec_rs2_idx(rs2), .dec_use_rs1(u1), .dec_use_rs2(u2),
        .ex_rd_idx(exrd), .ex_reg_write(exw), .ex_mem_load(exl),
        .mem_rd_idx(memrd), .mem_reg_write(memw), .jump_taken(jmp),
        .stall(b_stall), .bubble_ex(b_bub), .flush_dec(b_flush),
        .fwd_rs1_sel(b_f1), .fwd_rs2_sel(b_f2), .busy_flush(b_busy),
        .stall_cycles(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    // Reference model: squash cycles remaining after the current one, stall
    // count, and the forward selects due to appear after the next edge.
    int fc[2]   = '{c_fc0, c_fc1};
    int cmax[2] = '{(1 << c_cw0) - 1, (1 << c_cw1) - 1};
    int rem[2];
    int cnt[2];
    int fsel1[2];
    int fsel2[2];
    bit e_stall[2], e_bub[2], e_flush[2];
    bit m_ex1, m_ex2, m_mem1, m_mem2;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0; cnt[i] = 0; fsel1[i] = 0; fsel2[i] = 0;
        end
    endtask

    task automatic eval_comb();
        bit haz;
        m_ex1  = u1 && exw  && exrd  == rs1 && rs1 != 0;
        m_ex2  = u2 && exw  && exrd  == rs2 && rs2 != 0;
        m_mem1 = u1 && memw && memrd == rs1 && rs1 != 0;
        m_mem2 = u2 && memw && memrd == rs2 && rs2 != 0;
        if (c_fwd_on) haz = (m_ex1 || m_ex2) && exl;
        else          haz = m_ex1 || m_ex2 || m_mem1 || m_mem2;
        for (int i = 0; i < 2; i++) begin
            e_stall[i] = 0; e_bub[i] = 0; e_flush[i] = 0;
            if (rem[i] > 0) e_flush[i] = 1;
            else if (jmp) begin e_flush[i] = 1; e_bub[i] = 1; end
            else if (haz) begin e_stall[i] = 1; e_bub[i] = 1; end
        end
    endtask

    task automatic model_tick();
        for (int i = 0; i < 2; i++) begin
            bit squash = e_stall[i] || e_bub[i] || e_flush[i];
            if (rem[i] > 0) rem[i] = rem[i] - 1;
            else if (jmp)   rem[i] = fc[i] - 1;
            if (e_stall[i] && cnt[i] < cmax[i]) cnt[i] = cnt[i] + 1;
            if (!c_fwd_on || squash) begin
                fsel1[i] = 0; fsel2[i] = 0;
            end else begin
                fsel1[i] = m_ex1 ? 1 : (m_mem1 ? 2 : 0);
                fsel2[i] = m_ex2 ? 1 : (m_mem2 ? 2 : 0);
            end
        end
    endtask

    // One clock: model advances with the edge, new inputs follow 1 time unit
    // later; returns just after the falling edge where outputs are compared.
    task automatic step(input logic [4:0] a_rs1, input logic [4:0] a_rs2,
                        input logic a_u1, input logic a_u2,
                        input logic [4:0] a_exrd, input logic a_exw, input logic a_exl,
                        input logic [4:0] a_memrd, input logic a_memw, input logic a_jmp);
        @(posedge clk);
        if (reset_n) model_tick();
        #1;
        rs1 = a_rs1; rs2 = a_rs2; u1 = a_u1; u2 = a_u2;
        exrd = a_exrd; exw = a_exw; exl = a_exl;
        memrd = a_memrd; memw = a_memw; jmp = a_jmp;
        eval_comb();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("a_stall", int'(a_stall), int'(e_stall[0]));
            chk("a_bubble", int'(a_bub), int'(e_bub[0]));
            chk("a_flush", int'(a_flush), int'(e_flush[0]));
            chk("a_busy", int'(a_busy), int'(rem[0] > 0));
            chk("a_fwd1", int'(a_f1), fsel1[0]);
            chk("a_fwd2", int'(a_f2), fsel2[0]);
            chk("a_cnt", int'(a_cnt), cnt[0]);
            chk("b_stall", int'(b_stall), int'(e_stall[1]));
            chk("b_bubble", int'(b_bub), int'(e_bub[1]));
            chk("b_flush", int'(b_flush), int'(e_flush[1]));
            chk("b_busy", int'(b_busy), int'(rem[1] > 0));
            chk("b_fwd1", int'(b_f1), fsel1[1]);
            chk("b_fwd2", int'(b_f2), fsel2[1]);
            chk("b_cnt", int'(b_cnt), cnt[1]);
        end
    end

    initial begin
        reset_n = 1'b1;
        rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; exrd = 0; exw = 0; exl = 0;
        memrd = 0; memw = 0; jmp = 0;
        model_reset();
        eval_comb();
        #1 reset_n = 1'b0;
        #1;
        chk("rst_cnt", int'(a_cnt), 0);
        chk("rst_busy", int'(a_busy), 0);
        chk("rst_fwd1", int'(a_f1), 0);
        chk("rst_stall", int'(a_stall), 0);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        check_en = 1'b1;

        // Jump together with a load-use hazard: jump wins, no stall counted.
        step(5, 0, 1, 0, 5, 1, 1, 0, 0, 1);
        chk("jmp_haz_stall", int'(a_stall), 0);
        chk("jmp_haz_flush", int'(a_flush), 1);
        chk("jmp_haz_busy", int'(a_busy), 0);
        // Second squash cycle in FLUSH: hazard ignored.
        step(5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
        chk("flush2_flush", int'(a_flush), 1);
        chk("flush2_busy", int'(a_busy), 1);
        chk("flush2_stall", int'(a_stall), 0);
        chk("flush2_cnt", int'(a_cnt), 0);
        idle();
        chk("after_flush_a", int'(a_flush), 0);
        chk("after_flush_a_busy", int'(a_busy), 0);
        chk("flush3_b_busy", int'(b_busy), 1);
        chk("stall_cnt_kept", int'(a_cnt), 0);
        idle();
        chk("after_flush_b", int'(b_flush), 0);

`ifdef HAZARD_FORWARD_EN
        step(5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
        chk("ldu_stall", int'(a_stall), 1);
        chk("ldu_bubble", int'(a_bub), 1);
        step(5, 0, 1, 0, 0, 0, 0, 5, 1, 0);
        chk("ldu_next_stall", int'(a_stall), 0);
        idle();
        chk("ldu_fwd_mem", int'(a_f1), 2);
        step(0, 7, 0, 1, 7, 1, 0, 0, 0, 0);
        chk("alu_stall", int'(a_stall), 0);
        step(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        chk("alu_fwd_ex", int'(a_f2), 1);
        idle();
        chk("x0_fwd", int'(a_f2), 0);
`else
        step(3, 0, 1, 0, 3, 1, 0, 0, 0, 0);
        chk("ex_haz_stall", int'(a_stall), 1);
        step(3, 0, 1, 0, 0, 0, 0, 3, 1, 0);
        chk("mem_haz_stall", int'(a_stall), 1);
        step(3, 0, 1, 0, 3, 1, 0, 0, 0, 0);
        chk("two_stalls_cnt", int'(a_cnt), 2);
        step(3, 0, 1, 0, 3, 1, 0, 0, 0, 0);
        step(3, 0, 1, 0, 3, 1, 0, 0, 0, 0);
        idle();
        chk("five_stalls_cnt", int'(a_cnt), 5);
        chk("sat_cnt", int'(b_cnt), 3);
        chk("fwd_off_sel", int'(a_f1), 0);
`endif

        // Asynchronous reset in the middle of a flush.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        chk("pre_rst_busy", int'(a_busy), 1);
        #1;
        check_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("arst_flush", int'(a_flush), 0);
        chk("arst_busy", int'(a_busy), 0);
        chk("arst_stall", int'(a_stall), 0);
        chk("arst_b_flush", int'(b_flush), 0);
        chk("arst_b_busy", int'(b_busy), 0);
        chk("arst_fwd", int'(a_f1) + int'(a_f2), 0);
        model_reset();
        @(negedge clk);
        #2 reset_n = 1'b1;
        eval_comb();
        check_en = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("post_rst_jump", int'(a_flush), 1);
        chk("post_rst_busy", int'(a_busy), 0);

        for (int n = 0; n < 3000; n++) begin
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 3)), 1'($urandom),
                 1'($urandom_range(0, 9) == 0));
        end

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
